// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer:
//   - FSM state encodings (IDLE/LOAD/WAIT/HOLD/DONE; 5..7 are illegal)
//   - ALU in_sel constants (persist / load / reset)
//   - one-hot ALU operation constants OP_6..OP_0
//   - pick_highest(): one-hot of the highest set bit of a vector
// No ports; imported by alu_seq_picker and alu_op_sequencer.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    // Widest op vector supported by the selector (rd_idx is 3 bits wide).
    localparam int MAX_OPS = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;

    localparam logic [6:0] OP_6 = 7'b1000000;
    localparam logic [6:0] OP_5 = 7'b0100000;
    localparam logic [6:0] OP_4 = 7'b0010000;
    localparam logic [6:0] OP_3 = 7'b0001000;
    localparam logic [6:0] OP_2 = 7'b0000100;
    localparam logic [6:0] OP_1 = 7'b0000010;
    localparam logic [6:0] OP_0 = 7'b0000001;

    // One-hot of the most significant set bit; all-zero input gives zero.
    function automatic logic [MAX_OPS-1:0] pick_highest(input logic [MAX_OPS-1:0] vec);
        logic [MAX_OPS-1:0] result;
        logic               found;
        result = '0;
        found  = 1'b0;
        for (int i = MAX_OPS - 1; i >= 0; i--) begin
            if (!found && vec[i]) begin
                result[i] = 1'b1;
                found     = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_seq_picker.sv
// -----------------------------------------------------------------------------
// alu_seq_picker
// Combinational highest-set-bit selector over NOPS bits (NOPS <= MAX_OPS).
// Ports:
//   vec    in  NOPS  candidate operation bits
//   onehot out NOPS  one-hot of the highest set bit of vec (zero if vec==0)
// -----------------------------------------------------------------------------
module alu_seq_picker
    import alu_seq_pkg::*;
#(
    parameter int NOPS = 7
) (
    input  logic [NOPS-1:0] vec,
    output logic [NOPS-1:0] onehot
);

    logic [MAX_OPS-1:0] vec_ext_s;
    logic [MAX_OPS-1:0] pick_ext_s;

    // Zero-extend to the selector width, pick, then narrow back.
    always_comb begin
        vec_ext_s            = '0;
        vec_ext_s[NOPS-1:0]  = vec;
        pick_ext_s           = pick_highest(vec_ext_s);
        onehot               = pick_ext_s[NOPS-1:0];
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// On-chip initiator for the 8-bit ALU: loads two operands, then walks the
// set bits of op_mask from MSB to LSB, waits ALU_LAT cycles per op, captures
// alu_out and offers it on a valid/ready result channel.
//
// Ports:
//   clk, rst (async, active-low)
//   start, abort, num1_in, num2_in, op_mask    control / sequence setup
//   alu_out                                   ALU result input
//   on, in_sel, num1, num2, out_sel           ALU drive (registered)
//   res_valid, res_ready, res_data, res_op    result channel
//   busy, done, state                         status
// Optional (macro ALU_SEQ_RESULT_BUF_EN):
//   rd_idx in 3 / rd_data out W : read port of a per-op result buffer
// All outputs except rd_data come straight from flops.
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int W       = 8,
    parameter int NOPS    = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [W-1:0]    num1_in,
    input  logic [W-1:0]    num2_in,
    input  logic [NOPS-1:0] op_mask,
    input  logic [W-1:0]    alu_out,
    output logic            on,
    output logic [2:0]      in_sel,
    output logic [W-1:0]    num1,
    output logic [W-1:0]    num2,
    output logic [NOPS-1:0] out_sel,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [W-1:0]    res_data,
    output logic [NOPS-1:0] res_op,
    output logic            busy,
    output logic            done,
    output logic [2:0]      state
`ifdef ALU_SEQ_RESULT_BUF_EN
    ,
    input  logic [2:0]      rd_idx,
    output logic [W-1:0]    rd_data
`endif
);

    localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    state_e          state_r,     state_nxt_s;
    logic [NOPS-1:0] pending_r,   pending_nxt_s;
    logic [CW-1:0]   cnt_r,       cnt_nxt_s;
    logic [W-1:0]    num1_r,      num1_nxt_s;
    logic [W-1:0]    num2_r,      num2_nxt_s;
    logic            on_r,        on_nxt_s;
    logic [2:0]      in_sel_r,    in_sel_nxt_s;
    logic [NOPS-1:0] out_sel_r,   out_sel_nxt_s;
    logic            res_valid_r, res_valid_nxt_s;
    logic [W-1:0]    res_data_r,  res_data_nxt_s;
    logic [NOPS-1:0] res_op_r,    res_op_nxt_s;
    logic            busy_r,      busy_nxt_s;
    logic            done_r,      done_nxt_s;

    logic [NOPS-1:0] first_s;
    logic [NOPS-1:0] remain_s;
    logic [NOPS-1:0] next_s;
    logic            recover_s;
    logic            capture_s;
    logic            start_acc_s;

    // Ops still to run once the op currently on out_sel is retired.
    assign remain_s    = pending_r & ~out_sel_r;
    assign capture_s   = (state_r == ST_WAIT) && (cnt_r <= CW'(1));
    assign start_acc_s = (state_r == ST_IDLE) && start;
    // Abort in a live state, or an illegal encoding, drops back to IDLE.
    assign recover_s   = (abort && (state_r != ST_IDLE)) || (state_r > ST_DONE);

    alu_seq_picker #(.NOPS(NOPS)) u_pick_first (
        .vec    (pending_r),
        .onehot (first_s)
    );

    alu_seq_picker #(.NOPS(NOPS)) u_pick_next (
        .vec    (remain_s),
        .onehot (next_s)
    );

    // Next-state and next-output computation for every registered output.
    always_comb begin
        state_nxt_s     = state_r;
        pending_nxt_s   = pending_r;
        cnt_nxt_s       = cnt_r;
        num1_nxt_s      = num1_r;
        num2_nxt_s      = num2_r;
        on_nxt_s        = on_r;
        in_sel_nxt_s    = in_sel_r;
        out_sel_nxt_s   = out_sel_r;
        res_valid_nxt_s = res_valid_r;
        res_data_nxt_s  = res_data_r;
        res_op_nxt_s    = res_op_r;
        done_nxt_s      = 1'b0;

        if (recover_s) begin
            // Reset values everywhere except the operand registers.
            state_nxt_s     = ST_IDLE;
            pending_nxt_s   = '0;
            cnt_nxt_s       = '0;
            on_nxt_s        = 1'b0;
            in_sel_nxt_s    = SEL_RESET;
            out_sel_nxt_s   = '0;
            res_valid_nxt_s = 1'b0;
            res_data_nxt_s  = '0;
            res_op_nxt_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s && (op_mask != '0)) begin
                        num1_nxt_s    = num1_in;
                        num2_nxt_s    = num2_in;
                        pending_nxt_s = op_mask;
                        on_nxt_s      = 1'b1;
                        in_sel_nxt_s  = SEL_LOAD;
                        out_sel_nxt_s = '0;
                        state_nxt_s   = ST_LOAD;
                    end else if (start_acc_s) begin
                        // Empty mask: straight to the end-of-sequence pulse.
                        on_nxt_s      = 1'b0;
                        in_sel_nxt_s  = SEL_RESET;
                        out_sel_nxt_s = '0;
                        done_nxt_s    = 1'b1;
                        state_nxt_s   = ST_DONE;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    on_nxt_s      = 1'b1;
                    in_sel_nxt_s  = SEL_PERSIST;
                    out_sel_nxt_s = first_s;
                    cnt_nxt_s     = CW'(ALU_LAT);
                    state_nxt_s   = ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture_s) begin
                        res_data_nxt_s  = alu_out;
                        res_op_nxt_s    = out_sel_r;
                        res_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_HOLD;
                    end else begin
                        cnt_nxt_s       = cnt_r - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (res_ready && (next_s != '0)) begin
                        res_valid_nxt_s = 1'b0;
                        pending_nxt_s   = remain_s;
                        out_sel_nxt_s   = next_s;
                        cnt_nxt_s       = CW'(ALU_LAT);
                        state_nxt_s     = ST_WAIT;
                    end else if (res_ready) begin
                        res_valid_nxt_s = 1'b0;
                        pending_nxt_s   = remain_s;
                        on_nxt_s        = 1'b0;
                        in_sel_nxt_s    = SEL_RESET;
                        out_sel_nxt_s   = '0;
                        done_nxt_s      = 1'b1;
                        state_nxt_s     = ST_DONE;
                    end else begin
                        state_nxt_s     = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r   <= '0;
            cnt_r       <= '0;
            num1_r      <= '0;
            num2_r      <= '0;
            on_r        <= 1'b0;
            in_sel_r    <= SEL_RESET;
            out_sel_r   <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_op_r    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pending_r   <= pending_nxt_s;
            cnt_r       <= cnt_nxt_s;
            num1_r      <= num1_nxt_s;
            num2_r      <= num2_nxt_s;
            on_r        <= on_nxt_s;
            in_sel_r    <= in_sel_nxt_s;
            out_sel_r   <= out_sel_nxt_s;
            res_valid_r <= res_valid_nxt_s;
            res_data_r  <= res_data_nxt_s;
            res_op_r    <= res_op_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign state     = state_r;
    assign on        = on_r;
    assign in_sel    = in_sel_r;
    assign num1      = num1_r;
    assign num2      = num2_r;
    assign out_sel   = out_sel_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_op    = res_op_r;
    assign busy      = busy_r;
    assign done      = done_r;

`ifdef ALU_SEQ_RESULT_BUF_EN
    logic [W-1:0] buf_r [NOPS];

    // Per-op result buffer: cleared at start, written on each capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NOPS; i++) begin
                buf_r[i] <= '0;
            end
        end else if (start_acc_s) begin
            for (int i = 0; i < NOPS; i++) begin
                buf_r[i] <= '0;
            end
        end else if (capture_s && !abort) begin
            for (int i = 0; i < NOPS; i++) begin
                if (out_sel_r[i]) begin
                    buf_r[i] <= alu_out;
                end else begin
                    buf_r[i] <= buf_r[i];
                end
            end
        end else begin
            for (int i = 0; i < NOPS; i++) begin
                buf_r[i] <= buf_r[i];
            end
        end
    end

    // Combinational read; indices without an entry return zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NOPS; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_data = buf_r[i];
            end else begin
                rd_data = rd_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer (ALU_LAT=1, W=8, NOPS=7) with a
// behavioural ALU and a queue-based expected-result model.
// Build with ALU_SEQ_RESULT_BUF_EN defined to also cover the result buffer.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] num1_in;
    logic [7:0] num2_in;
    logic [6:0] op_mask;
    logic [7:0] alu_out;
    logic       on;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [6:0] out_sel;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [6:0] res_op;
    logic       busy;
    logic       done;
    logic [2:0] state;
`ifdef ALU_SEQ_RESULT_BUF_EN
    logic [2:0] rd_idx;
    logic [7:0] rd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_op_sequencer #(.ALU_LAT(1), .W(8), .NOPS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .num1_in   (num1_in),
        .num2_in   (num2_in),
        .op_mask   (op_mask),
        .alu_out   (alu_out),
        .on        (on),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .out_sel   (out_sel),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .busy      (busy),
        .done      (done),
        .state     (state)
`ifdef ALU_SEQ_RESULT_BUF_EN
        ,
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operation table of the ALU being driven.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [6:0] op);
        case (op)
            7'b1000000: return a + b;
            7'b0100000: return a - b;
            7'b0010000: return a & b;
            7'b0001000: return a | b;
            7'b0000100: return a ^ b;
            7'b0000010: return a << 1;
            7'b0000001: return ~a;
            default:    return 8'h00;
        endcase
    endfunction

    // Behavioural ALU: operand latch on load, clear on reset select.
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a <= 8'h00;
            alu_b <= 8'h00;
        end else if (on && in_sel == 3'b010) begin
            alu_a <= num1;
            alu_b <= num2;
        end else if (in_sel == 3'b001) begin
            alu_a <= 8'h00;
            alu_b <= 8'h00;
        end
    end
    assign alu_out = on ? alu_f(alu_a, alu_b, out_sel) : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sequence against the expected-result queue.
    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [6:0] mask,
                           input int stall, input bit rnd_ready, input bit timed);
        logic [7:0] exp_d[$];
        logic [6:0] exp_o[$];
        logic [6:0] oh;
        logic [7:0] hd;
        logic [6:0] ho;
        int cyc, nres, nexp, ndone, done_cyc, busy_cyc, stall_left;
        bit fresh;
        for (int i = 6; i >= 0; i--) begin
            if (mask[i]) begin
                oh = 7'b0000001 << i;
                exp_o.push_back(oh);
                exp_d.push_back(alu_f(a, b, oh));
            end
        end
        nexp = exp_d.size();
        start = 1'b1; num1_in = a; num2_in = b; op_mask = mask; res_ready = 1'b1;
        step();
        start = 1'b0; num1_in = 8'($urandom); num2_in = 8'($urandom); op_mask = 7'($urandom);
        cyc = 1; nres = 0; ndone = 0; done_cyc = 0; busy_cyc = 0; stall_left = stall; fresh = 1'b1;
        hd = 8'h00; ho = 7'h00;
        while (cyc < 400) begin
            if (done) begin ndone++; done_cyc = cyc; end
            if (busy) busy_cyc++;
            if (ndone > 0 && state == 3'd0) break;
            if (res_valid) begin
                if (fresh) begin
                    if (exp_d.size() == 0) begin
                        check("extra_result", 32'(1), 32'(0));
                    end else begin
                        check("res_data", 32'(res_data), 32'(exp_d[0]));
                        check("res_op", 32'(res_op), 32'(exp_o[0]));
                        if (timed) check("res_cycle", 32'(cyc), 32'(3 + 2 * nres));
                    end
                    hd = res_data; ho = res_op; fresh = 1'b0;
                end else begin
                    check("hold_data", 32'(res_data), 32'(hd));
                    check("hold_op", 32'(res_op), 32'(ho));
                end
                if (stall_left > 0) begin
                    res_ready = 1'b0; stall_left--;
                end else if (rnd_ready) begin
                    res_ready = 1'($urandom_range(0, 1));
                end else begin
                    res_ready = 1'b1;
                end
                if (res_ready) begin
                    if (exp_d.size() > 0) begin void'(exp_d.pop_front()); void'(exp_o.pop_front()); end
                    nres++; fresh = 1'b1;
                end
            end else begin
                res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            // start pulses while busy must be ignored
            start = res_valid;
            step();
            cyc++;
        end
        start = 1'b0; res_ready = 1'b1;
        check("done_count", 32'(ndone), 32'(1));
        check("n_results", 32'(nres), 32'(nexp));
        check("busy_cycles", 32'(busy_cyc), 32'(done_cyc));
        if (timed) check("done_cycle", 32'(done_cyc), 32'((nexp == 0) ? 1 : 2 * nexp + 2));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_valid", 32'(res_valid), 32'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'(0));
        check({tag, "_on"}, 32'(on), 32'(0));
        check({tag, "_in_sel"}, 32'(in_sel), 32'(3'b001));
        check({tag, "_out_sel"}, 32'(out_sel), 32'(0));
        check({tag, "_valid"}, 32'(res_valid), 32'(0));
        check({tag, "_res"}, 32'({res_data, 1'b0, res_op}), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        logic [7:0] a, b;
        logic [6:0] m;
        bit done_seen;
        rst = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        num1_in = 8'h00; num2_in = 8'h00; op_mask = 7'h00;
`ifdef ALU_SEQ_RESULT_BUF_EN
        rd_idx = 3'd0;
`endif
        #22;
        check_reset_vals("rst");
        check("rst_num", 32'({num1, num2}), 32'(0));
        rst = 1'b1;
        step();

        // Directed: full mask with fixed operands, exact timing.
        run_seq(8'h57, 8'h1A, 7'b1111111, 0, 1'b0, 1'b1);
`ifdef ALU_SEQ_RESULT_BUF_EN
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            m = 7'b0000001 << i;
            check("rd_data", 32'(rd_data), 32'((i < 7) ? alu_f(8'h57, 8'h1A, m) : 8'h00));
        end
`endif
        step();

        // Back-pressure in the first HOLD.
        run_seq(8'hC3, 8'h3C, 7'b0100010, 5, 1'b0, 1'b0);
        step();

        // Empty mask.
        run_seq(8'h11, 8'h22, 7'b0000000, 0, 1'b0, 1'b1);
        step();

        // Abort in HOLD together with a handshake.
        a = 8'($urandom); b = 8'($urandom);
        start = 1'b1; num1_in = a; num2_in = b; op_mask = 7'b0010100; res_ready = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 50 && !res_valid; k++) step();
        check("abort_reach_hold", 32'(res_valid), 32'(1));
        abort = 1'b1; res_ready = 1'b1;
        step();
        abort = 1'b0;
        check_reset_vals("abort");
        check("abort_num", 32'({num1, num2}), 32'({a, b}));
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done || busy) done_seen = 1'b1;
            step();
        end
        check("abort_no_done", 32'(done_seen), 32'(0));

        // Asynchronous reset in WAIT.
        start = 1'b1; num1_in = 8'h9A; num2_in = 8'h44; op_mask = 7'b1111111;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && state != 3'd2; k++) step();
        check("reach_wait", 32'(state), 32'(2));
        #2 rst = 1'b0;
        #1;
        check_reset_vals("async");
        check("async_num", 32'({num1, num2}), 32'(0));
        step();
        #2 rst = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done || busy) done_seen = 1'b1;
        end
        check("rst_no_done", 32'(done_seen), 32'(0));

        // Randomised sequences with random back-pressure.
        for (int t = 0; t < 12; t++) begin
            a = 8'($urandom); b = 8'($urandom); m = 7'($urandom);
            run_seq(a, b, m, 0, 1'b1, 1'b0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
